// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM encodings and oversampling constants used by
// both the transmitter and this receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and baud tick in, recovered byte out.
interface uart_rx_if #(
  parameter int WIDTH = 8
);
  logic             s_tick;
  logic             rx;
  logic [WIDTH-1:0] dout;
  logic             rx_done_tick;
  logic             frame_err;

  modport master (
    output s_tick,
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err
  );

  modport slave (
    input  s_tick,
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both stages
// reset to RESET_VAL so an idle-high line stays idle through reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: LSB-first frames of WIDTH data bits, one
// start bit, SB_TICK/16 stop bits, no parity. SB_TICK must be at least 16.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int S_W = $clog2(SB_TICK);
  localparam int N_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [S_W-1:0] S_MID      = S_W'(MID_TICK);
  localparam logic [S_W-1:0] S_BIT_END  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST     = N_W'(WIDTH - 1);

  logic rx_s;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.rx),
    .q  (rx_s)
  );

  uart_state_e      state_d, state_q;
  logic [S_W-1:0]   s_d, s_q;
  logic [N_W-1:0]   n_d, n_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] dout_d, dout_q;
  logic             done_d, done_q;
  logic             ferr_d, ferr_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    unique case (state_q)
      IDLE: begin
        // Start detection is tick-independent so back-to-back frames lose no time.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d = '0;
            b_d = {rx_s, b_q[WIDTH-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP_END) begin
            // A low stop sample still delivers the byte, flagged as a framing error.
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
endmodule
